apb_param_regfile: RTL
======================

# apb_param_regfile

Parametrised APB4 slave register file: next generation of the fixed 16-bit, four-register APB target in the accelerator's control path. It generalises data width, register count and wait-state count. It adds per-register read-only protection, range/permission error signalling on pslverr, and a hardware-side update port per register. It sits between the APB interconnect and the crypto/SPI datapath, whose configuration it exposes as flat register outputs.

## Interface
- DATA_W, 16: data bus width; multiple of 8, 8..64
- ADDR_W, 8: paddr width
- NUM_REGS, 4: number of registers, 1..2**ADDR_W
- WAIT_STATES, 0: wait cycles inserted in every access phase, 0..15
- RO_MASK, 0: NUM_REGS bits; bit i set = register i read-only from APB
- RESET_VAL, 0: DATA_W reset value for every register
- pclk  in  1  clock
- presetn  in  1  reset, synchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write
- paddr  in  ADDR_W  register index (word addressing, index = paddr)
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte-lane write strobes
- prdata  out  DATA_W  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error
- hw_we  in  NUM_REGS  per-register hardware update enable
- hw_wdata  in  NUM_REGS*DATA_W  hardware update data, register i at [i*DATA_W +: DATA_W]
- reg_q  out  NUM_REGS*DATA_W  current register contents, same packing

## Operation
- FSM states: IDLE, ACCESS. Wait counter cnt has width 4.
- IDLE: psel=1 and penable=0 (setup) -> ACCESS, cnt loaded with WAIT_STATES. Anything else stays IDLE.
- ACCESS, psel=0: abort. Go to IDLE with no write and no response.
- ACCESS, psel=1 and cnt!=0: cnt decrements and pready=0.
- ACCESS, psel=1 and cnt==0: pready=1 (completion cycle); next state IDLE.
- Error (err) = index >= NUM_REGS, or (pwrite and RO_MASK[index]). Evaluated on the completion cycle.
- Write commit: at the completion-cycle edge, when !err. Each byte lane k with pstrb[k]=1 takes pwdata; other lanes keep their value. pstrb==0 is legal: no change, no error.
- Read: on the completion cycle prdata = register[index] if !err, else 0. prdata = 0 in every other cycle. pstrb is ignored on reads.
- pslverr = err on the completion cycle, 0 otherwise.
- Hardware update: hw_we[i]=1 loads hw_wdata slice i into register i at the next edge. This applies regardless of RO_MASK.
- Collision, same register, same edge: APB-strobed byte lanes take pwdata; unstrobed lanes take hw_wdata.
- Different registers updated in the same cycle both take effect.
- reg_q reflects registers directly, with no extra delay.

## Timing
- Reset (presetn=0 at a pclk edge): registers=RESET_VAL, state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0. hw_we is ignored during reset.
- Reset asserted mid-ACCESS: transfer abandoned, no write. pready=0 from the following cycle.
- pready, pslverr and prdata are decoded from state, cnt, the registers and the current paddr/pwrite. They carry no combinational path from pwdata.
- Latency: completion in access cycle WAIT_STATES+1. A full transfer takes WAIT_STATES+2 cycles including setup.
- Written value is visible on reg_q one cycle after the completion edge.
- Back-to-back: a setup phase in the cycle immediately after completion is accepted. No dead cycle is needed.
- paddr, pwrite, pwdata and pstrb must be held stable from setup through completion. Otherwise behaviour is undefined.
- WAIT_STATES=0: pready=1 in the first access cycle.

## Test plan
Configuration for all scenarios: DATA_W=16, NUM_REGS=4, RO_MASK=4'b0100, WAIT_STATES=2, RESET_VAL=0.
- Reset, then read indices 0..3 -> prdata 0x0000 each, pslverr 0. pready high exactly in the 3rd access cycle. reg_q=0.
- Write idx0 0xdead pstrb 11; idx1 0x4ead pstrb 10; idx3 0xfeed pstrb 00 -> readback 0xdead, 0x4e00, 0x0000, all pslverr 0.
- Write idx2 (RO) 0x1234 -> pslverr 1, readback 0x0000. Read idx5 -> pslverr 1, prdata 0x0000.
- hw_we[0] with 0x1111 on the same edge as an APB write to idx0 of 0xabcd pstrb 01 -> reg0=0x11cd. hw_we[2] with 0x5a5a -> reg2=0x5a5a despite RO.
- psel dropped in the 1st wait cycle of a write to idx1 -> no pready, reg1 unchanged. A following read completes normally.
- presetn low during ACCESS of a write to idx0 0xbeef -> pready 0 next cycle, all reg_q 0, no write. Back-to-back writes to idx0 and idx1 with no idle cycle between -> both committed.

Source files
------------

// File: rtl/apb_param_regfile.sv
// APB4 slave register file with configurable width, depth and wait states.
// Adds per-register read-only protection, pslverr signalling and a hardware update port per register.
module apb_param_regfile #(
    parameter int                   DATA_W      = 16,
    parameter int                   ADDR_W      = 8,
    parameter int                   NUM_REGS    = 4,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] regs_next [NUM_REGS];

    logic              complete;
    logic              hit_valid;
    logic              hit_ro;
    logic              err;
    logic              apb_wr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] strb_mask;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_next = ACCESS;
                    cnt_next   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign complete = (state == ACCESS) && psel && (cnt == 4'd0);

    // Address decode by comparison so paddr wider than the register index never over-indexes.
    always_comb begin
        hit_valid = 1'b0;
        hit_ro    = 1'b0;
        rd_data   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (paddr == ADDR_W'(i)) begin
                hit_valid = 1'b1;
                hit_ro    = RO_MASK[i];
                rd_data   = regs[i];
            end
        end
    end

    assign err    = !hit_valid || (pwrite && hit_ro);
    assign apb_wr = complete && pwrite && !err;

    always_comb begin
        strb_mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            strb_mask[k*8 +: 8] = {8{pstrb[k]}};
        end
    end

    // Hardware load first, then strobed APB lanes on top, so a collision keeps hw data in unstrobed lanes.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (hw_we[i]) begin
                regs_next[i] = hw_wdata[i*DATA_W +: DATA_W];
            end
            if (apb_wr && (paddr == ADDR_W'(i))) begin
                regs_next[i] = (regs_next[i] & ~strb_mask) | (pwdata & strb_mask);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_next[i];
            end
        end
    end

    assign pready  = complete;
    assign pslverr = complete && err;
    assign prdata  = (complete && !pwrite && !err) ? rd_data : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
